// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the Ethernet parser front end.
package eth_parser_pkg;

   // Bytes captured from the start of each frame (MACs, TPID/TCI, inner ethertype)
   localparam int unsigned ETH_HDR_CAPTURE_BYTES   = 18;
   // Shortest frame that still carries a complete untagged L2 header
   localparam int unsigned ETH_MIN_FRAME_HDR_BYTES = 14;

   // Index = byte offset within the frame
   typedef logic [ETH_HDR_CAPTURE_BYTES-1:0][7:0] eth_header_bytes_t;
   typedef logic [15:0]                           ethertype_t;

   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      DRAIN   = 2'd1,
      PRESENT = 2'd2
   } hdr_cap_state_t;

endpackage

// File: rtl/eth_header_capture.sv
// Captures the first 18 bytes of each inbound frame, counts the frame length and
// presents the header to the VLAN resolution stage until it is consumed.
module eth_header_capture
   import eth_parser_pkg::*;
#(
   parameter int unsigned FRAME_LEN_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   s_valid,
   input  logic [7:0]             s_data,
   input  logic                   s_last,
   output logic                   s_ready,
   output eth_header_bytes_t      header_bytes,
   output ethertype_t             ethertype_raw,
   output logic                   fields_valid,
   input  logic                   hdr_ready,
   output logic [FRAME_LEN_W-1:0] frame_len,
   output logic                   runt_err
);

   localparam logic [4:0] LastHdrIdx = 5'(ETH_HDR_CAPTURE_BYTES - 1);
   localparam logic [4:0] MinHdrCnt  = 5'(ETH_MIN_FRAME_HDR_BYTES);

   hdr_cap_state_t         state_q, state_d;
   logic [4:0]             byte_cnt_q, byte_cnt_d;
   logic [FRAME_LEN_W-1:0] frame_len_q, frame_len_d;
   eth_header_bytes_t      header_q, header_d;
   logic                   runt_q, runt_d;

   logic                   transfer;
   logic [4:0]             beat_cnt;
   logic [FRAME_LEN_W-1:0] frame_len_inc;

   // Ready depends only on state so there is no path from the stream inputs
   assign s_ready  = (state_q != PRESENT);
   assign transfer = s_valid & s_ready;
   // Byte count including the beat currently being accepted
   assign beat_cnt = byte_cnt_q + 5'd1;
   assign frame_len_inc = (frame_len_q == {FRAME_LEN_W{1'b1}}) ? frame_len_q
                                                               : frame_len_q + 1'b1;

   // Next-state logic for the capture FSM and its datapath
   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      frame_len_d = frame_len_q;
      header_d    = header_q;
      runt_d      = 1'b0;
      unique case (state_q)
         CAPTURE: begin
            if (transfer) begin
               header_d[byte_cnt_q] = s_data;
               byte_cnt_d           = beat_cnt;
               frame_len_d          = frame_len_inc;
               if (s_last) begin
                  if (beat_cnt < MinHdrCnt) begin
                     // Too short to hold a header: drop it and flag the runt
                     runt_d      = 1'b1;
                     byte_cnt_d  = '0;
                     frame_len_d = '0;
                     header_d    = '0;
                  end else begin
                     state_d = PRESENT;
                  end
               end else if (byte_cnt_q == LastHdrIdx) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (transfer) begin
               frame_len_d = frame_len_inc;
               if (s_last) begin
                  state_d = PRESENT;
               end
            end
         end
         PRESENT: begin
            if (hdr_ready) begin
               state_d     = CAPTURE;
               byte_cnt_d  = '0;
               frame_len_d = '0;
               header_d    = '0;
            end
         end
         default: begin
            state_d = CAPTURE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CAPTURE;
         byte_cnt_q  <= '0;
         frame_len_q <= '0;
         header_q    <= '0;
         runt_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         frame_len_q <= frame_len_d;
         header_q    <= header_d;
         runt_q      <= runt_d;
      end
   end

   // Outputs straight from registers; ethertype is a pure byte selection
   always_comb begin
      header_bytes  = header_q;
      ethertype_raw = {header_q[12], header_q[13]};
      fields_valid  = (state_q == PRESENT);
      frame_len     = frame_len_q;
      runt_err      = runt_q;
   end

endmodule

// File: tb/tb_eth_header_capture.sv
// Directed + randomized bench for eth_header_capture; two instances share stimulus so
// both the default 16-bit and a saturating 8-bit frame counter are checked.
module tb_eth_header_capture;
   import eth_parser_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              s_valid = 1'b0;
   logic [7:0]        s_data = '0;
   logic              s_last = 1'b0;
   logic              hdr_ready = 1'b0;

   logic              s_ready, s_ready8;
   eth_header_bytes_t hdr16, hdr8;
   ethertype_t        et16, et8;
   logic              fv16, fv8;
   logic [15:0]       fl16;
   logic [7:0]        fl8;
   logic              runt16, runt8;

   int                n_tests = 0;
   int                n_fail = 0;
   bit                use_gaps = 1'b0;
   logic [7:0]        frm[$];

   eth_header_capture u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_last       (s_last),
      .s_ready      (s_ready),
      .header_bytes (hdr16),
      .ethertype_raw(et16),
      .fields_valid (fv16),
      .hdr_ready    (hdr_ready),
      .frame_len    (fl16),
      .runt_err     (runt16)
   );

   eth_header_capture #(.FRAME_LEN_W(8)) u_dut8 (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_last       (s_last),
      .s_ready      (s_ready8),
      .header_bytes (hdr8),
      .ethertype_raw(et8),
      .fields_valid (fv8),
      .hdr_ready    (hdr_ready),
      .frame_len    (fl8),
      .runt_err     (runt8)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: header is the first 18 frame bytes, zero beyond the frame end
   function automatic eth_header_bytes_t exp_hdr();
      eth_header_bytes_t h;
      h = '0;
      for (int i = 0; i < ETH_HDR_CAPTURE_BYTES; i++) begin
         if (i < frm.size()) h[i] = frm[i];
      end
      return h;
   endfunction

   function automatic int sat8(input int n);
      return (n > 255) ? 255 : n;
   endfunction

   task automatic build_frame(input int len);
      frm.delete();
      for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(0, 255)));
   endtask

   // Called at a negedge; returns at the negedge after the last accepted beat
   task automatic send_frame(input int n_send, output int first_stall);
      int waits;
      first_stall = 0;
      for (int i = 0; i < n_send; i++) begin
         if (use_gaps && i > 0 && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
         end
         s_valid = 1'b1;
         s_data  = frm[i];
         s_last  = (i == frm.size() - 1);
         waits   = 0;
         while (!s_ready && waits < 50) begin
            @(negedge clk);
            waits++;
         end
         if (!s_ready) begin
            chk("ready_timeout", 256'(s_ready), 256'(1));
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
         end
         if (i == 0) first_stall = waits;
         @(posedge clk);
         @(negedge clk);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Checks the cycle right after the final beat was accepted
   task automatic check_result(input string tag);
      int len;
      eth_header_bytes_t h;
      len = frm.size();
      h   = exp_hdr();
      if (len < ETH_MIN_FRAME_HDR_BYTES) begin
         chk({tag, "_runt"}, 256'({runt16, runt8}), 256'(2'b11));
         chk({tag, "_runt_fv"}, 256'({fv16, fv8}), 256'(2'b00));
         chk({tag, "_runt_rdy"}, 256'(s_ready), 256'(1));
         chk({tag, "_runt_len"}, 256'({fl16, fl8}), 256'(0));
         chk({tag, "_runt_hdr"}, 256'(hdr16), 256'(0));
         @(negedge clk);
         chk({tag, "_runt_pulse"}, 256'({runt16, runt8}), 256'(2'b00));
      end else begin
         chk({tag, "_fv"}, 256'({fv16, fv8}), 256'(2'b11));
         chk({tag, "_runt0"}, 256'({runt16, runt8}), 256'(2'b00));
         chk({tag, "_rdy0"}, 256'({s_ready, s_ready8}), 256'(2'b00));
         chk({tag, "_hdr"}, 256'(hdr16), 256'(h));
         chk({tag, "_hdr8"}, 256'(hdr8), 256'(h));
         chk({tag, "_etype"}, 256'(et16), 256'({h[12], h[13]}));
         chk({tag, "_len16"}, 256'(fl16), 256'(len));
         chk({tag, "_len8"}, 256'(fl8), 256'(sat8(len)));
      end
   endtask

   // Hold presentation for a while if hdr_ready is low, then consume
   task automatic release_hdr(input string tag, input int hold);
      if (!hdr_ready) begin
         repeat (hold) begin
            @(negedge clk);
            chk({tag, "_hold_fv"}, 256'(fv16), 256'(1));
            chk({tag, "_hold_len"}, 256'(fl16), 256'(frm.size()));
         end
         hdr_ready = 1'b1;
      end
      @(negedge clk);
      chk({tag, "_rel_fv"}, 256'(fv16), 256'(0));
      chk({tag, "_rel_rdy"}, 256'(s_ready), 256'(1));
      chk({tag, "_rel_clr"}, 256'({hdr16, fl16}), 256'(0));
   endtask

   initial begin
      int stall;
      int len;
      eth_header_bytes_t h;

      // Reset
      repeat (2) @(negedge clk);
      chk("rst_fv", 256'(fv16), 256'(0));
      chk("rst_runt", 256'(runt16), 256'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rdy", 256'(s_ready), 256'(1));
      chk("rst_state", 256'({hdr16, fl16, fv16, runt16}), 256'(0));

      // 64-byte untagged frame, consumed immediately
      build_frame(64);
      frm[12] = 8'h08;
      frm[13] = 8'h00;
      hdr_ready = 1'b1;
      send_frame(frm.size(), stall);
      check_result("untag64");
      chk("untag64_et", 256'(et16), 256'(16'h0800));
      release_hdr("untag64", 0);

      // Tagged frame held for 10 cycles
      build_frame(72);
      {frm[12], frm[13], frm[14], frm[15], frm[16], frm[17]} = 48'h8100_0064_86DD;
      hdr_ready = 1'b0;
      use_gaps = 1'b1;
      send_frame(frm.size(), stall);
      check_result("tag");
      h = exp_hdr();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("tag_hold_fv", 256'(fv16), 256'(1));
         chk("tag_hold_rdy", 256'(s_ready), 256'(0));
         chk("tag_hold_hdr", 256'({hdr16, fl16}), 256'({h, 16'(frm.size())}));
         chk("tag_hold_et", 256'(et16), 256'(16'h8100));
      end

      // Release while the next frame's first beat is already offered
      build_frame(60);
      hdr_ready = 1'b1;
      send_frame(frm.size(), stall);
      chk("back2back_stall", 256'(stall), 256'(1));
      check_result("next60");
      release_hdr("next60", 0);

      // Runt followed by a normal frame
      build_frame(10);
      send_frame(frm.size(), stall);
      check_result("runt10");
      build_frame(60);
      send_frame(frm.size(), stall);
      check_result("after_runt");
      release_hdr("after_runt", 0);

      // 15-byte frame: tail header bytes stay zero
      build_frame(15);
      hdr_ready = 1'b0;
      send_frame(frm.size(), stall);
      check_result("len15");
      chk("len15_tail", 256'({hdr16[17], hdr16[16], hdr16[15]}), 256'(0));
      release_hdr("len15", 2);

      // Boundary lengths around the runt limit and the capture window
      for (int k = 0; k < 6; k++) begin
         case (k)
            0: len = 13;
            1: len = 14;
            2: len = 17;
            3: len = 18;
            4: len = 19;
            default: len = 1;
         endcase
         build_frame(len);
         hdr_ready = 1'b0;
         send_frame(frm.size(), stall);
         check_result($sformatf("bnd%0d", len));
         if (len >= ETH_MIN_FRAME_HDR_BYTES) release_hdr("bnd", 1);
      end

      // 300-byte frame: 8-bit counter saturates, 16-bit does not
      build_frame(300);
      hdr_ready = 1'b1;
      send_frame(frm.size(), stall);
      check_result("len300");
      chk("len300_sat8", 256'(fl8), 256'(255));
      release_hdr("len300", 0);

      // Reset in the middle of a frame
      build_frame(64);
      send_frame(30, stall);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_clr", 256'({hdr16, fl16, fv16, runt16}), 256'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_runt", 256'({runt16, runt8}), 256'(0));
      chk("midrst_rdy", 256'(s_ready), 256'(1));
      build_frame(64);
      send_frame(frm.size(), stall);
      check_result("postrst64");
      release_hdr("postrst64", 0);

      // Randomized frames
      for (int k = 0; k < 30; k++) begin
         len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 13))
                                           : int'($urandom_range(14, 50));
         build_frame(len);
         hdr_ready = 1'($urandom_range(0, 1));
         use_gaps  = 1'($urandom_range(0, 1));
         send_frame(frm.size(), stall);
         check_result($sformatf("rnd%0d", k));
         if (len >= ETH_MIN_FRAME_HDR_BYTES) release_hdr("rnd", int'($urandom_range(1, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_header_capture.md
ETH_HEADER_CAPTURE -- requirements
Module: eth_header_capture

Interface
REQ-001 Parameter FRAME_LEN_W, default 16, width of the frame byte counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 s_valid  input  1  inbound byte-stream beat valid.
REQ-005 s_data  input  8  inbound frame byte, destination MAC first.
REQ-006 s_last  input  1  beat is final byte of frame.
REQ-007 s_ready  output  1  block accepts beat; transfer = s_valid & s_ready.
REQ-008 header_bytes  output  eth_header_bytes_t  captured frame bytes 0..17, index = byte offset.
REQ-009 ethertype_raw  output  ethertype_t  {header_bytes[12], header_bytes[13]}.
REQ-010 fields_valid  output  1  header_bytes/ethertype_raw/frame_len complete and stable.
REQ-011 hdr_ready  input  1  downstream consumes presented header.
REQ-012 frame_len  output  FRAME_LEN_W  byte count of presented frame, saturating.
REQ-013 runt_err  output  1  one-cycle pulse: frame dropped, under 14 bytes.

Function
REQ-014 FSM states CAPTURE, DRAIN, PRESENT; s_ready = 1 in CAPTURE and DRAIN, 0 in PRESENT; fields_valid = 1 only in PRESENT.
REQ-015 CAPTURE: each transfer writes s_data to header_bytes[byte_cnt], increments byte_cnt (5 bits, 0..18) and frame_len.
REQ-016 CAPTURE, transfer with s_last, byte count incl. this beat < 14: runt_err pulses next cycle, byte_cnt/frame_len/header_bytes cleared, stay CAPTURE.
REQ-017 CAPTURE, transfer with s_last, count 14..18: next state PRESENT; unwritten bytes 14..17 remain 0x00.
REQ-018 CAPTURE, transfer of byte 17 without s_last: next state DRAIN.
REQ-019 DRAIN: bytes discarded, header_bytes unchanged, frame_len increments; transfer with s_last -> PRESENT.
REQ-020 frame_len saturates at all-ones; further beats do not wrap it.
REQ-021 Latency: fields_valid asserts the cycle after the s_last transfer is accepted.
REQ-022 PRESENT: outputs held constant until hdr_ready sampled 1; then next state CAPTURE, byte_cnt, frame_len, header_bytes cleared to 0 in the same edge.
REQ-023 fields_valid & hdr_ready and a new s_valid in the same cycle: the beat is not accepted (s_ready = 0); first byte of next frame accepted the following cycle at earliest.
REQ-024 ethertype_raw derived combinationally from header_bytes registers; no extra latency.
REQ-025 s_ready has no combinational path from s_valid, s_data, s_last or hdr_ready.

Reset
REQ-026 rst_n low: state CAPTURE, byte_cnt 0, frame_len 0, header_bytes all 0x00, fields_valid 0, runt_err 0; s_ready 1 after deassertion.
REQ-027 Reset mid-frame or mid-PRESENT discards the frame with no runt_err; first beat after deassertion is treated as byte 0.

Structure
REQ-028 eth_parser_pkg carries ETH_HDR_CAPTURE_BYTES = 18, ETH_MIN_FRAME_HDR_BYTES = 14 and enum hdr_cap_state_t {CAPTURE, DRAIN, PRESENT}; module reuses existing eth_header_bytes_t and ethertype_t.
REQ-029 Single flat module, no sub-modules; outputs feed the VLAN resolution stage directly (header_bytes, ethertype_raw, fields_valid).

Verification
REQ-030 64-byte untagged frame, bytes 12..13 = 0x08,0x00, hdr_ready held 1 -> fields_valid one cycle, ethertype_raw 0x0800, frame_len 64, header_bytes[0..17] match stimulus.
REQ-031 Tagged frame, bytes 12..17 = 81 00 00 64 86 DD, hdr_ready 0 for 10 cycles -> fields_valid held 10+ cycles, s_ready 0, outputs stable, ethertype_raw 0x8100.
REQ-032 10-byte frame with s_last -> runt_err single pulse, no fields_valid, next 60-byte frame captured correctly.
REQ-033 15-byte frame -> PRESENT with frame_len 15, header_bytes[15..17] = 0x00.
REQ-034 FRAME_LEN_W = 8, 300-byte frame -> frame_len 255.
REQ-035 rst_n pulsed at byte 30 of a frame, then a clean 64-byte frame -> no runt_err, second frame presented correctly with frame_len 64.
